if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch stage that generates the sequential PC, issues requests to instruction memory, buffers in-order responses, and presents one `if_pc`/`if_instr` pair per cycle to the IF/ID pipeline register. It is the producer side of the IF/ID interface. It honours the same stall signal that freezes IF/ID and flushes on branch/jump redirects from execute. When no fetched instruction is ready, it injects a NOP bubble.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, entry-buffer slots (in-flight plus returned), power of two, ≥2
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `stall_if`  in  1  1 = downstream IF/ID holding; outputs must stay stable, no pop
- `jump_flag`  in  1  redirect request from execute
- `jump_addr`  in  32  redirect target
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_req_addr`  out  32  fetch address, word aligned
- `imem_rsp_valid`  in  1  response valid; responses return in request order, no backpressure
- `imem_rsp_data`  in  32  instruction word
- `if_pc`  out  32  PC of presented instruction
- `if_instr`  out  32  presented instruction

## Operation
- State: `fetch_pc`; circular buffer of `DEPTH` entries {pc, instr, done}; head/tail pointers plus occupancy `cnt`; `drop_cnt` (responses owed to flushed requests).
- Issue: `imem_req_valid = !jump_flag && (cnt - pop + drop_cnt) < DEPTH`, with `imem_req_addr = fetch_pc`. On accept (`valid && ready`): allocate tail entry with pc = `fetch_pc`, done=0; `fetch_pc += 4` (32-bit wrap, no trap).
- Response: if `drop_cnt > 0`, discard and decrement. Otherwise write `instr` into the oldest not-done entry and set done=1.
- Present: if head entry done, `if_pc`/`if_instr` = head pc/instr; else `if_pc = 0`, `if_instr = NOP_INSTR`.
- Pop: head entry removed when `!stall_if && head done && !jump_flag`.
- Jump (priority over stall, response, and pop): clear all entries (`cnt = 0`). `drop_cnt` = current `drop_cnt` + allocated-not-done entries − (1 if a response arrives this cycle). `fetch_pc = jump_addr`. No request is issued in the jump cycle, and `imem_req_valid` may fall without acceptance only in that cycle. The memory side tolerates this retraction.
- Misaligned `jump_addr`: the low two bits are forced to 0.
- Stall with empty head: the NOP bubble stays presented. Prefetch continues until the buffer is full.

## Timing
- Reset (async assert): `fetch_pc = RESET_PC`, `cnt = 0`, `drop_cnt = 0`, `if_pc = 0`, `if_instr = NOP_INSTR`. `imem_req_valid` is 0 while `rst = 0`, and is 1 in the first cycle after release if not jumping.
- Reset mid-operation discards all entries and owed drops. The memory is reset in the same domain.
- Latency with a zero-wait memory (request accepted at cycle N, response at N+1): instruction appears on `if_instr` at N+2. It is captured by IF/ID at the N+3 edge.
- Steady state: one instruction per cycle with `DEPTH ≥ 2`. Issue counts a same-cycle pop as freed space.
- Outputs are combinational from head registers only, with no input-to-output paths. `imem_req_valid` depends combinationally on `jump_flag`.
- After a jump at cycle J, the first request to `jump_addr` issues at J+1. The target is presented no earlier than J+3.
- Simultaneous response and pop: both apply. A response may fill the entry allocated the previous cycle or any older not-done entry.

## Test plan
- Reset release, memory always ready with 1-cycle response returning `instr = addr ^ 32'hA5A5_0000`: `if_pc` sequence is 0,4,8,… from the third cycle, one per cycle, with no bubbles.
- Hold `stall_if = 1` for 5 cycles mid-stream at `if_pc = 0x10`: `if_pc`/`if_instr` stay stable. Requests stop after 4 outstanding/buffered. Release resumes at 0x14 with no skip or duplicate.
- `imem_req_ready` low for 3 cycles at `addr = 0x8`: `imem_req_addr` is held at 0x8. NOP bubbles are presented once the buffer drains. No address is skipped.
- `jump_flag` with `jump_addr = 0x100` while 2 requests are in flight: both late responses are dropped. The next presented instruction has `if_pc = 0x100`. No stale PC appears.
- `jump_flag` in the same cycle as a response and a pending pop: the response is discarded, `drop_cnt` is correct, and the next valid output is `if_pc = jump_addr`.
- Assert `rst = 0` asynchronously mid-stream at `if_pc = 0x20`: outputs go immediately to `if_pc = 0` and `if_instr = 0x0000_0013`. Fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, in-order imem requests,
// a circular entry buffer for in-flight/returned instructions, and a NOP
// bubble when the head instruction has not yet returned.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_if,
  input  logic                    jump_flag,
  input  logic [31:0]             jump_addr,
  if_fetch_unit_if.master         imem,
  output logic [31:0]             if_pc,
  output logic [31:0]             if_instr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0]      fetch_pc;
  logic [31:0]      buf_pc    [DEPTH];
  logic [31:0]      buf_instr [DEPTH];
  logic [DEPTH-1:0] buf_done;
  ptr_t             head;
  ptr_t             tail;
  cnt_t             cnt;       // allocated entries
  cnt_t             pend;      // allocated entries still waiting for data
  cnt_t             drop_cnt;  // responses owed to flushed requests

  logic head_done;
  logic pop;
  logic issue;
  logic accept;
  logic rsp_fill;
  logic rsp_drop;
  logic rsp_used;
  ptr_t fill_idx;
  cnt_t occ;

  assign head_done = (cnt != '0) && buf_done[head];
  assign pop       = !stall_if && head_done && !jump_flag;
  assign accept    = issue && imem.imem_req_ready;
  assign rsp_drop  = imem.imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill  = imem.imem_rsp_valid && (drop_cnt == '0) && (pend != '0);
  assign rsp_used  = rsp_drop || rsp_fill;
  // Not-done entries are always the youngest 'pend' ones, since responses
  // come back in request order; the oldest of them sits pend slots behind tail.
  assign fill_idx  = tail - ptr_t'(pend);

  // Issue when space remains, counting a same-cycle pop as freed and owed
  // drops as occupied; never in a jump cycle or while held in reset.
  always_comb begin
    occ   = cnt - cnt_t'(pop) + drop_cnt;
    issue = rst && !jump_flag && (occ < cnt_t'(DEPTH));
  end

  assign imem.imem_req_valid = issue;
  assign imem.imem_req_addr  = fetch_pc;

  // Present the head entry when its data has returned, otherwise a bubble.
  always_comb begin
    if_pc    = '0;
    if_instr = NOP_INSTR;
    if (head_done) begin
      if_pc    = buf_pc[head];
      if_instr = buf_instr[head];
    end
  end

  // Control state: PC, pointers, occupancy, outstanding-drop bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      buf_done <= '0;
    end else if (jump_flag) begin
      // Every still-pending request becomes an owed drop; a response landing
      // in this cycle pays one of them (or an existing drop) off already.
      fetch_pc <= {jump_addr[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      pend     <= '0;
      drop_cnt <= drop_cnt + pend - cnt_t'(rsp_used);
      buf_done <= '0;
    end else begin
      if (accept) begin
        buf_done[tail] <= 1'b0;
        tail           <= tail + ptr_t'(1);
        fetch_pc       <= fetch_pc + 32'd4;
      end
      if (rsp_fill) begin
        buf_done[fill_idx] <= 1'b1;
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - cnt_t'(1);
      end
      if (pop) begin
        head <= head + ptr_t'(1);
      end
      cnt  <= cnt + cnt_t'(accept) - cnt_t'(pop);
      pend <= pend + cnt_t'(accept) - cnt_t'(rsp_fill);
    end
  end

  // Entry payload storage; validity is tracked by buf_done and cnt.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_pc[tail] <= fetch_pc;
    end
    if (rsp_fill && !jump_flag) begin
      buf_instr[fill_idx] <= imem.imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: table-driven cycle vectors against
// a fixed-latency instruction memory returning addr ^ 32'hA5A5_0000.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (4),
    .NOP_INSTR (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_if  (stall_if),
    .jump_flag (jump_flag),
    .jump_addr (jump_addr),
    .imem      (bus),
    .if_pc     (if_pc),
    .if_instr  (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: accepted request returns 'lat' cycles later (lat 1..3).
  int unsigned lat;
  logic [3:0]  pv;
  logic [31:0] pd [4];

  assign bus.imem_rsp_valid = pv[0];
  assign bus.imem_rsp_data  = pd[0];

  // Response delay line, shifted toward slot 0 every cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      for (int i = 0; i < 4; i++) pd[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        pv[i] <= pv[i+1];
        pd[i] <= pd[i+1];
      end
      pv[3] <= 1'b0;
      pd[3] <= '0;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pv[lat-1] <= 1'b1;
        pd[lat-1] <= bus.imem_req_addr ^ KEY;
      end
    end
  end

  typedef struct {
    logic        stall;
    logic        jump;
    logic [31:0] jaddr;
    logic        ready;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[$];
  int checks;
  int failures;

  function automatic vec_t v(input logic stall, input logic jump,
                             input logic [31:0] jaddr, input logic ready,
                             input logic [31:0] pc, input logic bubble,
                             input logic vld, input logic [31:0] addr);
    vec_t r;
    r.stall     = stall;
    r.jump      = jump;
    r.jaddr     = jaddr;
    r.ready     = ready;
    r.exp_pc    = bubble ? 32'h0 : pc;
    r.exp_instr = bubble ? NOP : (pc ^ KEY);
    r.exp_valid = vld;
    r.exp_addr  = addr;
    return r;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%08h expected=%08h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset(input int unsigned latency);
    lat       = latency;
    rst       = 1'b0;
    stall_if  = 1'b0;
    jump_flag = 1'b0;
    jump_addr = '0;
    bus.imem_req_ready = 1'b1;
    #1;
    chk("rst_pc",    0, if_pc, 32'h0);
    chk("rst_instr", 0, if_instr, NOP);
    chk("rst_valid", 0, {31'b0, bus.imem_req_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Apply each vector for one cycle starting just after a rising edge.
  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      stall_if           = tbl[i].stall;
      jump_flag          = tbl[i].jump;
      jump_addr          = tbl[i].jaddr;
      bus.imem_req_ready = tbl[i].ready;
      @(negedge clk);
      chk({tag, "_pc"},    i, if_pc,    tbl[i].exp_pc);
      chk({tag, "_instr"}, i, if_instr, tbl[i].exp_instr);
      chk({tag, "_valid"}, i, {31'b0, bus.imem_req_valid}, {31'b0, tbl[i].exp_valid});
      chk({tag, "_addr"},  i, bus.imem_req_addr, tbl[i].exp_addr);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    // Stream from reset, then a 5-cycle stall while 0x10 is presented.
    do_reset(1);
    tbl.delete();
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 1, 32'h0));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 1, 32'h4));
    for (int k = 2; k <= 5; k++)
      tbl.push_back(v(0, 0, 0, 1, 32'(4*(k-2)), 0, 1, 32'(4*k)));
    tbl.push_back(v(1, 0, 0, 1, 32'h10, 0, 1, 32'h18));
    tbl.push_back(v(1, 0, 0, 1, 32'h10, 0, 1, 32'h1C));
    tbl.push_back(v(1, 0, 0, 1, 32'h10, 0, 0, 32'h20));
    tbl.push_back(v(1, 0, 0, 1, 32'h10, 0, 0, 32'h20));
    tbl.push_back(v(1, 0, 0, 1, 32'h10, 0, 0, 32'h20));
    for (int m = 0; m < 6; m++)
      tbl.push_back(v(0, 0, 0, 1, 32'(32'h10 + 4*m), 0, 1, 32'(32'h20 + 4*m)));
    run_table("stall");

    // Memory not ready for 3 cycles while 0x8 is offered.
    do_reset(1);
    tbl.delete();
    tbl.push_back(v(0, 0, 0, 1, 0,     1, 1, 32'h0));
    tbl.push_back(v(0, 0, 0, 1, 0,     1, 1, 32'h4));
    tbl.push_back(v(0, 0, 0, 0, 32'h0, 0, 1, 32'h8));
    tbl.push_back(v(0, 0, 0, 0, 32'h4, 0, 1, 32'h8));
    tbl.push_back(v(0, 0, 0, 0, 0,     1, 1, 32'h8));
    tbl.push_back(v(0, 0, 0, 1, 0,     1, 1, 32'h8));
    tbl.push_back(v(0, 0, 0, 1, 0,     1, 1, 32'hC));
    tbl.push_back(v(0, 0, 0, 1, 32'h8, 0, 1, 32'h10));
    tbl.push_back(v(0, 0, 0, 1, 32'hC, 0, 1, 32'h14));
    tbl.push_back(v(0, 0, 0, 1, 32'h10, 0, 1, 32'h18));
    run_table("ready");

    // Two-cycle memory: jump to 0x100 with two requests in flight, one
    // response landing in the jump cycle and a pop pending.
    do_reset(2);
    tbl.delete();
    tbl.push_back(v(0, 0, 0,         1, 0,       1, 1, 32'h0));
    tbl.push_back(v(0, 0, 0,         1, 0,       1, 1, 32'h4));
    tbl.push_back(v(0, 0, 0,         1, 0,       1, 1, 32'h8));
    tbl.push_back(v(0, 0, 0,         1, 32'h0,   0, 1, 32'hC));
    tbl.push_back(v(0, 0, 0,         1, 32'h4,   0, 1, 32'h10));
    tbl.push_back(v(0, 1, 32'h100,   1, 32'h8,   0, 0, 32'h14));
    tbl.push_back(v(0, 0, 0,         1, 0,       1, 1, 32'h100));
    tbl.push_back(v(0, 0, 0,         1, 0,       1, 1, 32'h104));
    tbl.push_back(v(0, 0, 0,         1, 0,       1, 1, 32'h108));
    tbl.push_back(v(0, 0, 0,         1, 32'h100, 0, 1, 32'h10C));
    tbl.push_back(v(0, 0, 0,         1, 32'h104, 0, 1, 32'h110));
    run_table("jump");

    // Misaligned jump target: low bits forced to zero.
    do_reset(1);
    tbl.delete();
    tbl.push_back(v(0, 0, 0,       1, 0,       1, 1, 32'h0));
    tbl.push_back(v(0, 0, 0,       1, 0,       1, 1, 32'h4));
    tbl.push_back(v(0, 0, 0,       1, 32'h0,   0, 1, 32'h8));
    tbl.push_back(v(0, 0, 0,       1, 32'h4,   0, 1, 32'hC));
    tbl.push_back(v(0, 1, 32'h203, 1, 32'h8,   0, 0, 32'h10));
    tbl.push_back(v(0, 0, 0,       1, 0,       1, 1, 32'h200));
    tbl.push_back(v(0, 0, 0,       1, 0,       1, 1, 32'h204));
    tbl.push_back(v(0, 0, 0,       1, 32'h200, 0, 1, 32'h208));
    tbl.push_back(v(0, 0, 0,       1, 32'h204, 0, 1, 32'h20C));
    run_table("misalign");

    // Asynchronous reset while 0x20 is presented, then restart.
    do_reset(1);
    tbl.delete();
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 1, 32'h0));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 1, 32'h4));
    for (int k = 2; k <= 9; k++)
      tbl.push_back(v(0, 0, 0, 1, 32'(4*(k-2)), 0, 1, 32'(4*k)));
    run_table("prerst");
    @(negedge clk);
    chk("mid_pc",    0, if_pc,    32'h20);
    chk("mid_instr", 0, if_instr, 32'h20 ^ KEY);
    #2 rst = 1'b0;
    #1;
    chk("async_pc",    0, if_pc,    32'h0);
    chk("async_instr", 0, if_instr, NOP);
    chk("async_valid", 0, {31'b0, bus.imem_req_valid}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    tbl.delete();
    tbl.push_back(v(0, 0, 0, 1, 0,     1, 1, 32'h0));
    tbl.push_back(v(0, 0, 0, 1, 0,     1, 1, 32'h4));
    tbl.push_back(v(0, 0, 0, 1, 32'h0, 0, 1, 32'h8));
    tbl.push_back(v(0, 0, 0, 1, 32'h4, 0, 1, 32'hC));
    run_table("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
